// File: rtl/lcd_pkg.sv
// lcd_pkg: HD44780 command bytes, sequencer/writer state encodings and default
// 50 MHz timing shared by the character LCD driver.
package lcd_pkg;
   localparam logic [7:0] FUNC_SET_4B2L = 8'h28;
   localparam logic [7:0] ENTRY_INC = 8'h06;
   localparam logic [7:0] DISP_ON = 8'h0C;
   localparam logic [7:0] CLEAR = 8'h01;
   localparam logic [7:0] DDRAM_L1 = 8'h80;
   localparam logic [7:0] DDRAM_L2 = 8'hC0;
   localparam int T_POWERON_DEF = 750000;
   localparam int T_INIT_DEF = 205000;
   localparam int T_CMD_DEF = 2000;
   localparam int T_CLEAR_DEF = 82000;
   localparam int T_SETUP_DEF = 2;
   localparam int T_EHIGH_DEF = 12;
   localparam int T_HOLD_DEF = 2;
   localparam int T_NIBGAP_DEF = 50;
   typedef enum logic [2:0] {PWR_WAIT, INIT, CMD, ADDR1, LINE1, ADDR2, LINE2, DONE} lcd_state_e;
   typedef enum logic [2:0] {W_IDLE, W_SETUP, W_EHIGH, W_HOLD, W_WAIT} wr_state_e;
   function automatic int max2(int a, int b);
      return a > b ? a : b;
   endfunction
   function automatic logic [7:0] cmd_at(logic [1:0] i);
      return i == 2'd0 ? FUNC_SET_4B2L : i == 2'd1 ? ENTRY_INC : i == 2'd2 ? DISP_ON : CLEAR;
   endfunction
   // char k sits at line[127-8k -: 8], i.e. shifted down by 8*(15-k)
   function automatic logic [7:0] char_at(logic [127:0] line, logic [3:0] k);
      return 8'(line >> {~k, 3'b000});
   endfunction
endpackage

// File: rtl/lcd_char_driver_if.sv
// lcd_char_driver_if: string input, LCD pin drives and ready flag of the driver.
interface lcd_char_driver_if;
   logic [255:0] strdata;
   logic lcd_e;
   logic lcd_rs;
   logic lcd_rw;
   logic [3:0] lcd_dat;
   logic ready;
   modport master (input strdata, output lcd_e, lcd_rs, lcd_rw, lcd_dat, ready);
   modport slave (output strdata, input lcd_e, lcd_rs, lcd_rw, lcd_dat, ready);
endinterface

// File: rtl/lcd_nibble_writer.sv
// lcd_nibble_writer: one E strobe framed by setup/hold, followed by a caller-chosen
// idle wait; busy until that wait has elapsed.
module lcd_nibble_writer import lcd_pkg::*; #(
   parameter int T_SETUP = T_SETUP_DEF,
   parameter int T_EHIGH = T_EHIGH_DEF,
   parameter int T_HOLD = T_HOLD_DEF,
   parameter int CW = 20
) (
   input logic clk,
   input logic rst,
   input logic start_i,
   input logic rs_i,
   input logic [3:0] nib_i,
   input logic [CW-1:0] post_wait_i,
   output logic busy_o,
   output logic lcd_e_o,
   output logic lcd_rs_o,
   output logic [3:0] lcd_dat_o
);
   wr_state_e st_q;
   logic [CW-1:0] cnt_q, wait_q;
   logic last;
   assign busy_o = st_q != W_IDLE;
   always_comb begin
      last = st_q == W_SETUP ? cnt_q == CW'(T_SETUP - 1) :
             st_q == W_EHIGH ? cnt_q == CW'(T_EHIGH - 1) :
             st_q == W_HOLD ? cnt_q == CW'(T_HOLD - 1) : cnt_q == wait_q - 1'b1;
   end
   // E rises only when leaving SETUP, so every other phase end drives it low
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q <= W_IDLE;
         cnt_q <= '0;
         wait_q <= '0;
         lcd_e_o <= 1'b0;
         lcd_rs_o <= 1'b0;
         lcd_dat_o <= 4'h0;
      end else if (st_q == W_IDLE) begin
         if (start_i) begin
            st_q <= W_SETUP;
            cnt_q <= '0;
            wait_q <= post_wait_i;
            lcd_rs_o <= rs_i;
            lcd_dat_o <= nib_i;
         end
      end else if (last) begin
         cnt_q <= '0;
         st_q <= st_q == W_WAIT ? W_IDLE : wr_state_e'(st_q + 3'd1);
         lcd_e_o <= st_q == W_SETUP;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end
endmodule

// File: rtl/lcd_char_driver.sv
// lcd_char_driver: HD44780 4-bit init, clear and 2x16 text write from a latched string.
// Optional LCD_AUTO_REFRESH_EN: rewrite both lines T_CMD cycles after each DONE.
module lcd_char_driver import lcd_pkg::*; #(
   parameter int T_POWERON = T_POWERON_DEF,
   parameter int T_INIT = T_INIT_DEF,
   parameter int T_CMD = T_CMD_DEF,
   parameter int T_CLEAR = T_CLEAR_DEF,
   parameter int T_SETUP = T_SETUP_DEF,
   parameter int T_EHIGH = T_EHIGH_DEF,
   parameter int T_HOLD = T_HOLD_DEF,
   parameter int T_NIBGAP = T_NIBGAP_DEF
) (
   input logic clk,
   input logic rst,
   lcd_char_driver_if.master lcd_io
);
   localparam int T_MAX = max2(max2(max2(T_POWERON, T_INIT), max2(T_CMD, T_CLEAR)),
                               max2(max2(T_SETUP, T_EHIGH), max2(T_HOLD, T_NIBGAP)));
   localparam int CW = $clog2(T_MAX + 1);
   lcd_state_e state_q;
   logic [CW-1:0] cnt_q, post_wait;
   logic [3:0] idx_q, nib;
   logic [7:0] byte_v;
   logic [255:0] buf_q;
   logic lo_q, ready_q, busy, start, rs, init_ph, last_byte;
   // the first init nibble is issued on the last power-on cycle so E rises T_SETUP later
   always_comb begin
      init_ph = state_q == PWR_WAIT || state_q == INIT;
      rs = state_q == LINE1 || state_q == LINE2;
      start = !busy && (state_q == PWR_WAIT ? cnt_q == CW'(T_POWERON - 1) : state_q != DONE);
      byte_v = state_q == CMD ? cmd_at(idx_q[1:0]) : state_q == ADDR1 ? DDRAM_L1 :
               state_q == ADDR2 ? DDRAM_L2 :
               char_at(state_q == LINE1 ? buf_q[255:128] : buf_q[127:0], idx_q);
      nib = init_ph ? (idx_q == 4'd3 ? 4'h2 : 4'h3) : lo_q ? byte_v[3:0] : byte_v[7:4];
      post_wait = init_ph ? CW'(T_INIT) : !lo_q ? CW'(T_NIBGAP) :
                  (state_q == CMD && idx_q == 4'd3) ? CW'(T_CLEAR) : CW'(T_CMD);
      last_byte = state_q == CMD ? idx_q == 4'd3 : rs ? idx_q == 4'd15 : 1'b1;
   end
   lcd_nibble_writer #(.T_SETUP(T_SETUP), .T_EHIGH(T_EHIGH), .T_HOLD(T_HOLD), .CW(CW)) u_wr (
      .clk(clk),
      .rst(rst),
      .start_i(start),
      .rs_i(rs),
      .nib_i(nib),
      .post_wait_i(post_wait),
      .busy_o(busy),
      .lcd_e_o(lcd_io.lcd_e),
      .lcd_rs_o(lcd_io.lcd_rs),
      .lcd_dat_o(lcd_io.lcd_dat)
   );
   assign lcd_io.lcd_rw = 1'b0;
   assign lcd_io.ready = ready_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= PWR_WAIT;
         cnt_q <= '0;
         idx_q <= 4'd0;
         lo_q <= 1'b0;
         ready_q <= 1'b0;
         buf_q <= '0;
      end else begin
         case (state_q)
            PWR_WAIT: begin
               if (start) begin
                  state_q <= INIT;
                  idx_q <= 4'd1;
                  cnt_q <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            INIT: begin
               if (start) begin
                  idx_q <= idx_q == 4'd3 ? 4'd0 : idx_q + 1'b1;
                  if (idx_q == 4'd3) state_q <= CMD;
               end
            end
            DONE: begin
               if (!busy) ready_q <= 1'b1;
`ifdef LCD_AUTO_REFRESH_EN
               if (ready_q) begin
                  if (cnt_q == CW'(T_CMD - 1)) begin
                     state_q <= ADDR1;
                     buf_q <= lcd_io.strdata;
                     ready_q <= 1'b0;
                     cnt_q <= '0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
`endif
            end
            default: begin
               if (start) begin
                  lo_q <= !lo_q;
                  if (lo_q) begin
                     idx_q <= last_byte ? 4'd0 : idx_q + 1'b1;
                     if (last_byte) state_q <= lcd_state_e'(state_q + 3'd1);
                     if (state_q == CMD && last_byte) buf_q <= lcd_io.strdata;
                  end
               end
            end
         endcase
      end
   end
endmodule
